// File: rtl/perf_overflow_unit_pkg.sv
// Shared constants for the Sscofpmf overflow unit: XLEN, HPM counter count and CSR addresses.
package perf_overflow_unit_pkg;

  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] xlen_t;

  localparam int unsigned NrHpmCounters = 6;

  localparam logic [11:0] CsrMhpmEvent3  = 12'h323;
  localparam logic [11:0] CsrMhpmEvent3H = 12'h723;
  localparam logic [11:0] CsrMhpmEvent4H = 12'h724;
  localparam logic [11:0] CsrMhpmEvent5H = 12'h725;
  localparam logic [11:0] CsrMhpmEvent6H = 12'h726;
  localparam logic [11:0] CsrMhpmEvent7H = 12'h727;
  localparam logic [11:0] CsrMhpmEvent8H = 12'h728;
  localparam logic [11:0] CsrScountovf   = 12'hDA0;

  localparam int unsigned IrqSLcof = 13;

  // OF lives in mhpmevent[63] on RV64 and in mhpmeventh[31] on RV32.
  function automatic logic [11:0] evt_addr(input int unsigned idx);
    logic [11:0] base;
    base = (XLEN == 64) ? CsrMhpmEvent3 : CsrMhpmEvent3H;
    return base + 12'(idx);
  endfunction

endpackage

// File: rtl/perf_overflow_unit.sv
// Sscofpmf overflow tracking for mhpmcounter3..: sticky OF flags, LCOFI request and
// optional freeze of overflowed counters.
module perf_overflow_unit
  import perf_overflow_unit_pkg::*;
#(
  parameter int unsigned NumCounters = NrHpmCounters,
  parameter bit          FreezeOnOvf = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         debug_mode_i,
  input  logic [NumCounters-1:0][63:0] cnt_i,
  input  logic [NumCounters-1:0]       inc_i,
  input  logic [11:0]                  addr_i,
  input  logic                         we_i,
  input  xlen_t                        data_i,
  output xlen_t                        data_o,
  output logic [NumCounters-1:0]       of_o,
  output logic [NumCounters-1:0]       inhibit_o,
  output logic                         lcofi_irq_o,
  input  logic                         irq_clear_i
);

  localparam int unsigned OfBit = XLEN - 1;

  logic [NumCounters-1:0] ovf;
  logic [NumCounters-1:0] of_d, of_q;
  logic                   new_of;
  logic                   lcofi_d, lcofi_q;
  logic                   unused_data;

  assign unused_data = ^data_i;

  always_comb begin
    ovf  = '0;
    of_d = of_q;
    for (int n = 0; n < NumCounters; n++) begin
      ovf[n] = inc_i[n] && (&cnt_i[n]) && !debug_mode_i;
      // Hardware set takes priority over a coincident software write.
      if (ovf[n]) begin
        of_d[n] = 1'b1;
      end else if (we_i && (addr_i == evt_addr(n))) begin
        of_d[n] = data_i[OfBit];
      end
    end
    new_of  = |(ovf & ~of_q);
    lcofi_d = new_of | (lcofi_q & ~irq_clear_i);
  end

  always_comb begin
    data_o = '0;
    for (int n = 0; n < NumCounters; n++) begin
      if (addr_i == CsrScountovf) begin
        data_o[3+n] = of_q[n];
      end
      if (addr_i == evt_addr(n)) begin
        data_o[OfBit] = of_q[n];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      of_q    <= '0;
      lcofi_q <= 1'b0;
    end else begin
      of_q    <= of_d;
      lcofi_q <= lcofi_d;
    end
  end

  assign of_o        = of_q;
  assign inhibit_o   = FreezeOnOvf ? of_q : '0;
  assign lcofi_irq_o = lcofi_q;

endmodule
